line_buf_5row: RTL and testbench
================================

Name: line_buf_5row

Overview:
- Streaming 5-row line buffer for the OV5640 binary-image path.
- Accepts a raster-order 1-bit pixel stream, one pixel per enabled cycle, and emits a vertically aligned 5-pixel column per pixel.
- Output feeds the 5-row Gaussian filter's data_in_1..data_in_5 / en inputs; this block is the producer side of that column interface.

Parameters:
- IMG_WIDTH, 640, active pixels per line; legal range 8..2048.
- DATA_W, 1, bits per pixel; the filter path uses 1.
- CNT_W, 11, width of the column counter; must satisfy 2^CNT_W >= IMG_WIDTH.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sof  input  1  start-of-frame pulse, sampled only together with pix_valid (the marked pixel is pixel (0,0))
- pix_valid  input  1  pix_data valid this cycle
- pix_data  input  DATA_W  incoming pixel
- col_en  output  1  column outputs valid this cycle
- data_out_1  output  DATA_W  pixel from line n-4 (oldest)
- data_out_2  output  DATA_W  pixel from line n-3
- data_out_3  output  DATA_W  pixel from line n-2
- data_out_4  output  DATA_W  pixel from line n-1
- data_out_5  output  DATA_W  pixel from current line n
- col_idx  output  CNT_W  column index of the emitted column
- line_idx  output  3  number of lines fully buffered, saturating at 4

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: col_en=0, data_out_1..5=0, col_idx=0, line_idx=0, internal column pointer=0. Line-memory contents are not reset.
- Storage: four line memories (L1..L4), each IMG_WIDTH x DATA_W, addressed by the column pointer wptr.
- On each pix_valid cycle at column c:
  - Read L1[c]..L4[c].
  - Shift the column vertically: L1[c]<=L2[c], L2[c]<=L3[c], L3[c]<=L4[c], L4[c]<=pix_data.
  - Register outputs: data_out_1..4 <= old L1..L4[c], data_out_5 <= pix_data.
- Latency: exactly 1 cycle from the pix_valid sample to col_en/data_out. col_idx equals c.
- Column pointer:
  - Increments on each pix_valid.
  - At IMG_WIDTH-1 it wraps to 0 and line_idx increments, saturating at 4.
- Idle cycles (pix_valid=0): pointer, memories and line_idx hold. col_en=0. data_out_* hold their last values.
- col_en = registered (pix_valid && line_idx==4). No output until four full lines have been stored.
- sof with pix_valid:
  - Forces wptr=0 and line_idx=0 before this pixel is processed.
  - The pixel is written at column 0. Stale line data is ignored via line_idx.
  - sof without pix_valid is ignored.
- Mid-line sof: the partial line is discarded and the counters restart. No error flag.
- No backpressure; the downstream filter must accept every col_en cycle.
- Reset mid-line: all counters return to 0 on the next edge. The following pixel is treated as column 0 of an unbuffered frame.

Optional Feature:
- Macro: LINE_BUF_ZERO_PAD_EN.
- Defined:
  - col_en = registered pix_valid from the first line of the frame.
  - Any data_out_k whose source line is not yet buffered outputs 0. data_out_1 is zero while line_idx<4, data_out_2 while <3, data_out_3 while <2, data_out_4 while <1.
  - This gives top-border zero padding.
- Undefined: behaviour as specified above, and the padding logic is absent.

Test Plan:
- Fill (IMG_WIDTH=8): rst, then sof on pixel 0 and 40 pixels with value = line parity (lines 0..4 = 0,1,0,1,0) -> col_en low for the first 32 pixels. From pixel 32, col_en=1 with data_out_1..5 = 0,1,0,1,0 and col_idx 0..7.
- Wrap/saturation: 6 lines of 8 pixels -> line_idx reads 1,2,3,4,4. col_idx wraps 7->0. Line 5 outputs lines 1..5.
- Gaps: pix_valid toggled 1-0-0-1 during line 4 -> col_en mirrors pix_valid delayed 1 cycle. data_out_* hold during gaps. No pixel is lost or duplicated.
- Mid-line sof: sof at col 5 of line 4 -> line_idx=0, col_en stays 0 for the next 32 pixels. The restarted frame's column 0 is pixel 0.
- Reset mid-operation: rst at line 3, col 4 -> all outputs 0 on the next cycle. Refill then behaves as the Fill test.
- LINE_BUF_ZERO_PAD_EN defined: pixels of all 1s -> line 0 outputs 0,0,0,0,1 and line 2 outputs 0,0,1,1,1, with col_en=1 from the first pixel.

Source files
------------

// File: rtl/line_buf_5row.sv
// Streaming 5-row line buffer: turns a raster 1-bit pixel stream into vertically aligned 5-pixel columns.
// Optional top-border zero padding is built when LINE_BUF_ZERO_PAD_EN is defined.
module line_buf_5row #(
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned CNT_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              col_en,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic [DATA_W-1:0] data_out_3,
  output logic [DATA_W-1:0] data_out_4,
  output logic [DATA_W-1:0] data_out_5,
  output logic [CNT_W-1:0]  col_idx,
  output logic [2:0]        line_idx
);

  localparam int unsigned ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
  localparam logic [2:0] FULL_LINES = 3'd4;

  // mem1 holds the oldest buffered line, mem4 the most recent one
  logic [DATA_W-1:0] mem1 [IMG_WIDTH];
  logic [DATA_W-1:0] mem2 [IMG_WIDTH];
  logic [DATA_W-1:0] mem3 [IMG_WIDTH];
  logic [DATA_W-1:0] mem4 [IMG_WIDTH];

  logic [CNT_W-1:0]  wptr;
  logic [CNT_W-1:0]  ptr_c;
  logic [2:0]        line_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] rd1_c, rd2_c, rd3_c, rd4_c;

  // sof restarts the frame before the marked pixel is processed
  always_comb begin
    ptr_c  = sof ? '0 : wptr;
    line_c = sof ? '0 : line_idx;
    addr_c = ptr_c[ADDR_W-1:0];
    rd1_c  = mem1[addr_c];
    rd2_c  = mem2[addr_c];
    rd3_c  = mem3[addr_c];
    rd4_c  = mem4[addr_c];
  end

  // Vertical shift of one column through the four line memories
  always_ff @(posedge clk) begin
    if (pix_valid && !rst) begin
      mem1[addr_c] <= rd2_c;
      mem2[addr_c] <= rd3_c;
      mem3[addr_c] <= rd4_c;
      mem4[addr_c] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_en     <= 1'b0;
      data_out_1 <= '0;
      data_out_2 <= '0;
      data_out_3 <= '0;
      data_out_4 <= '0;
      data_out_5 <= '0;
      col_idx    <= '0;
      line_idx   <= '0;
      wptr       <= '0;
    end else begin
      col_en <= 1'b0;
      if (pix_valid) begin
        col_idx    <= ptr_c;
        data_out_5 <= pix_data;
`ifdef LINE_BUF_ZERO_PAD_EN
        // Rows above the top of the frame read as zero
        col_en     <= 1'b1;
        data_out_1 <= (line_c < 3'd4) ? '0 : rd1_c;
        data_out_2 <= (line_c < 3'd3) ? '0 : rd2_c;
        data_out_3 <= (line_c < 3'd2) ? '0 : rd3_c;
        data_out_4 <= (line_c < 3'd1) ? '0 : rd4_c;
`else
        col_en     <= (line_c == FULL_LINES);
        data_out_1 <= rd1_c;
        data_out_2 <= rd2_c;
        data_out_3 <= rd3_c;
        data_out_4 <= rd4_c;
`endif
        if (ptr_c == LAST_COL) begin
          wptr     <= '0;
          line_idx <= (line_c == FULL_LINES) ? FULL_LINES : line_c + 3'd1;
        end else begin
          wptr     <= ptr_c + CNT_W'(1);
          line_idx <= line_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_buf_5row.sv
// Self-checking bench for line_buf_5row: frame-image reference model feeding an expected-result queue.
module tb_line_buf_5row;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk, rst, sof, pix_valid;
  logic [0:0]       pix_data;
  logic             col_en;
  logic [0:0]       data_out_1, data_out_2, data_out_3, data_out_4, data_out_5;
  logic [CNT_W-1:0] col_idx;
  logic [2:0]       line_idx;

  line_buf_5row #(.IMG_WIDTH(W), .DATA_W(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data),
    .col_en(col_en), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .data_out_3(data_out_3), .data_out_4(data_out_4), .data_out_5(data_out_5),
    .col_idx(col_idx), .line_idx(line_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             col_en;
    bit               chk_data;
    logic [4:0]       data;
    logic [CNT_W-1:0] col_idx;
    logic [2:0]       line_idx;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model: the whole current frame as a 2-D image
  logic             hist [0:63][0:W-1];
  int               ln = 0;
  int               col = 0;
  logic [4:0]       last_data = '0;
  bit               known = 1'b0;
  logic [CNT_W-1:0] last_idx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (line %0d col %0d, t=%0t)", name, act, exp, ln, col, $time);
    end
  endtask

  function automatic logic [2:0] sat_lines(input int n);
    return (n > 4) ? 3'd4 : 3'(n);
  endfunction

  task automatic step(input logic r, input logic v, input logic s, input logic d);
    exp_t e;
    rst = r; pix_valid = v; sof = s; pix_data = d;
    if (r) begin
      ln = 0; col = 0; last_data = '0; known = 1'b1; last_idx = '0;
      e.col_en = 1'b0; e.chk_data = 1'b1; e.data = '0; e.col_idx = '0; e.line_idx = '0;
    end else if (v) begin
      logic [3:0] up;
      if (s) begin ln = 0; col = 0; end
      hist[ln & 63][col] = d;
      for (int k = 1; k <= 4; k++) begin
        int src = ln - 5 + k;
        up[4-k] = (src >= 0) ? hist[src & 63][col] : 1'b0;
      end
`ifdef LINE_BUF_ZERO_PAD_EN
      e.col_en = 1'b1;
`else
      e.col_en = (ln >= 4);
`endif
      e.data = {up, d};
      e.chk_data = e.col_en;
      e.col_idx = CNT_W'(col);
      known = e.col_en; last_data = e.data; last_idx = e.col_idx;
      col++;
      if (col == W) begin col = 0; ln++; end
      e.line_idx = sat_lines(ln);
    end else begin
      e.col_en = 1'b0; e.chk_data = known; e.data = last_data;
      e.col_idx = last_idx; e.line_idx = sat_lines(ln);
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("col_en", 32'(col_en), 32'(e.col_en));
      check("col_idx", 32'(col_idx), 32'(e.col_idx));
      check("line_idx", 32'(line_idx), 32'(e.line_idx));
      if (e.chk_data)
        check("data_out_1to5", 32'({data_out_1, data_out_2, data_out_3, data_out_4, data_out_5}),
              32'(e.data));
    end
  endtask

  // Pixel value for pattern: 0 = line parity, 1 = random, 2 = all ones
  function automatic logic pix_val(input int pat, input logic s);
    int eff_ln = s ? 0 : ln;
    case (pat)
      0:       return 1'(eff_ln & 1);
      1:       return 1'($urandom & 1);
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_pixels(input int n, input int pat, input bit sof_first);
    for (int i = 0; i < n; i++) begin
      logic s = sof_first && (i == 0);
      step(1'b0, 1'b1, s, pix_val(pat, s));
    end
  endtask

  typedef struct {
    bit         do_rst;
    bit         sof_first;
    int         npix;
    int         pat;
    logic [2:0] exp_line;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 40, 0, 3'd4};  // fill
    tbl[1] = '{1'b0, 1'b0, 8,  0, 3'd4};  // sixth line, saturation
    tbl[2] = '{1'b0, 1'b1, 21, 1, 3'd2};  // restart mid-line with random data
    tbl[3] = '{1'b0, 1'b0, 19, 1, 3'd4};
    tbl[4] = '{1'b1, 1'b1, 48, 2, 3'd4};  // all ones

    rst = 1'b1; sof = 1'b0; pix_valid = 1'b0; pix_data = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 5; t++) begin
      if (tbl[t].do_rst) step(1'b1, 1'b0, 1'b0, 1'b0);
      run_pixels(tbl[t].npix, tbl[t].pat, tbl[t].sof_first);
      check("table_line_idx", 32'(line_idx), 32'(tbl[t].exp_line));
    end

    // Gaps during line 4: valid 1-0-0-1
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_pixels(35, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);   // sof without valid is ignored
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_pixels(3, 0, 1'b0);
    check("gap_line_idx", 32'(line_idx), 32'd4);

    // Mid-line sof at col 5 of line 4
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_pixels(37, 1, 1'b1);
    run_pixels(1, 1, 1'b1);
    check("sof_restart_col", 32'(col_idx), 32'd0);
    check("sof_restart_line", 32'(line_idx), 32'd0);
    run_pixels(39, 1, 1'b0);
    check("sof_refill_col_en", 32'(col_en), 32'd1);

    // Reset at line 3 col 4, then refill without sof
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_pixels(28, 1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_pixels(40, 0, 1'b0);
    check("refill_data", 32'({data_out_1, data_out_2, data_out_3, data_out_4, data_out_5}),
          32'b01010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
